mem_read_responder: RTL and testbench

MEM_READ_RESPONDER -- requirements
Module: mem_read_responder

---
 rtl/mem_read_responder.sv | 112 +++++++++++
 tb/tb_mem_read_responder.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_read_responder.sv
// Single-outstanding read responder: accepts a fetch request, strobes the storage
// array, waits a per-request number of cycles, then returns the word with a valid pulse.
module mem_read_responder #(
    parameter int          ADDR_WIDTH  = 8,
    parameter int          DATA_WIDTH  = 8,
    parameter logic [3:0]  STOP_OPCODE = 4'b0001
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  MemRead,
    input  logic [ADDR_WIDTH-1:0] Addr,
    input  logic [1:0]            WaitStates,
    output logic [ADDR_WIDTH-1:0] ArrAddr,
    output logic                  ArrRd,
    input  logic [DATA_WIDTH-1:0] ArrData,
    output logic [DATA_WIDTH-1:0] DataOut,
    output logic                  DataValid,
    output logic                  Busy,
    output logic                  Halted
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    state_t                  state_q, state_d;
    logic [1:0]              cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   arr_addr_q, arr_addr_d;
    logic                    arr_rd_q, arr_rd_d;
    logic [DATA_WIDTH-1:0]   data_out_q, data_out_d;
    logic                    data_valid_q, data_valid_d;
    logic                    busy_q, busy_d;
    logic                    halted_q, halted_d;

    // Next-state and next-output logic for the request sequencer
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        arr_addr_d   = arr_addr_q;
        arr_rd_d     = 1'b0;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        halted_d     = halted_q;
        case (state_q)
            ST_IDLE: begin
                if (MemRead && !halted_q) begin
                    state_d    = ST_WAIT;
                    arr_addr_d = Addr;
                    cnt_d      = WaitStates;
                    arr_rd_d   = 1'b1;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q != 2'd0) begin
                    cnt_d = cnt_q - 2'd1;
                end else begin
                    data_out_d   = ArrData;
                    data_valid_d = 1'b1;
                    state_d      = ST_RESP;
                    // A stop word is still delivered; it only blocks later requests
                    if (ArrData[3:0] == STOP_OPCODE) begin
                        halted_d = 1'b1;
                    end else begin
                        halted_d = halted_q;
                    end
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 2'd0;
            arr_addr_q   <= '0;
            arr_rd_q     <= 1'b0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            arr_addr_q   <= arr_addr_d;
            arr_rd_q     <= arr_rd_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            busy_q       <= busy_d;
            halted_q     <= halted_d;
        end
    end

    assign ArrAddr   = arr_addr_q;
    assign ArrRd     = arr_rd_q;
    assign DataOut   = data_out_q;
    assign DataValid = data_valid_q;
    assign Busy      = busy_q;
    assign Halted    = halted_q;

endmodule

// File: tb/tb_mem_read_responder.sv
// Bench for mem_read_responder: directed vector table, random traffic against a
// transaction-timeline model, and hand sequences for hold, reset and halt cases.
module tb_mem_read_responder;

    logic       clock;
    logic       reset;
    logic       MemRead;
    logic [7:0] Addr;
    logic [1:0] WaitStates;
    logic [7:0] ArrAddr;
    logic       ArrRd;
    logic [7:0] ArrData;
    logic [7:0] DataOut;
    logic       DataValid;
    logic       Busy;
    logic       Halted;

    logic [7:0] mem [256];

    int errors = 0;
    int checks = 0;

    mem_read_responder #(
        .ADDR_WIDTH (8),
        .DATA_WIDTH (8),
        .STOP_OPCODE(4'b0001)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .MemRead   (MemRead),
        .Addr      (Addr),
        .WaitStates(WaitStates),
        .ArrAddr   (ArrAddr),
        .ArrRd     (ArrRd),
        .ArrData   (ArrData),
        .DataOut   (DataOut),
        .DataValid (DataValid),
        .Busy      (Busy),
        .Halted    (Halted)
    );

    assign ArrData = mem[ArrAddr];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: each accepted request is a timeline anchored at its accept edge
    int         e;
    int         acc_e;
    int         end_e;
    int         m_ws;
    logic [7:0] m_addr;
    logic       m_halted;
    logic [7:0] m_dout;
    logic [7:0] m_aa;
    logic       x_rd, x_dv, x_busy;

    task automatic model_reset();
        acc_e    = -100;
        end_e    = -100;
        m_ws     = 0;
        m_addr   = 8'h00;
        m_halted = 1'b0;
        m_dout   = 8'h00;
        m_aa     = 8'h00;
        x_rd     = 1'b0;
        x_dv     = 1'b0;
        x_busy   = 1'b0;
    endtask

    task automatic model_edge(input logic mr, input logic [7:0] a, input logic [1:0] ws);
        logic [7:0] word;
        if (!m_halted && mr && e > end_e) begin
            acc_e  = e;
            m_ws   = int'(ws);
            m_addr = a;
            m_aa   = a;
            end_e  = e + 2 + int'(ws);
        end
        x_rd   = (e == acc_e);
        x_dv   = (e == acc_e + 1 + m_ws);
        x_busy = (e >= acc_e) && (e < end_e);
        if (x_dv) begin
            word   = mem[m_addr];
            m_dout = word;
            if (word[3:0] == 4'b0001) m_halted = 1'b1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0h, expected %0h", name, e, act, exp);
        end
    endtask

    task automatic check_model();
        check("ArrRd",     {31'd0, ArrRd},     {31'd0, x_rd});
        check("DataValid", {31'd0, DataValid}, {31'd0, x_dv});
        check("Busy",      {31'd0, Busy},      {31'd0, x_busy});
        check("Halted",    {31'd0, Halted},    {31'd0, m_halted});
        check("DataOut",   {24'd0, DataOut},   {24'd0, m_dout});
        check("ArrAddr",   {24'd0, ArrAddr},   {24'd0, m_aa});
    endtask

    task automatic cyc(input logic mr, input logic [7:0] a, input logic [1:0] ws);
        MemRead    = mr;
        Addr       = a;
        WaitStates = ws;
        @(posedge clock);
        e++;
        model_edge(mr, a, ws);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ArrRd"},     {31'd0, ArrRd},     32'd0);
        check({tag, "_DataValid"}, {31'd0, DataValid}, 32'd0);
        check({tag, "_Busy"},      {31'd0, Busy},      32'd0);
        check({tag, "_Halted"},    {31'd0, Halted},    32'd0);
        check({tag, "_DataOut"},   {24'd0, DataOut},   32'd0);
        check({tag, "_ArrAddr"},   {24'd0, ArrAddr},   32'd0);
    endtask

    typedef struct {
        logic       mr;
        logic [7:0] addr;
        logic [1:0] ws;
        logic       rd;
        logic       dv;
        logic       busy;
        logic [7:0] dout;
        logic [7:0] aa;
    } vec_t;

    vec_t vt [10];
    int   n_rd, n_dv;

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'($urandom);
            if (mem[i][3:0] == 4'b0001) mem[i] = mem[i] ^ 8'h02;
        end
        mem[8'h05] = 8'h3A;
        mem[8'h10] = 8'h5C;
        mem[8'h40] = 8'hA6;
        mem[8'h41] = 8'h94;

        // Zero-wait request, then a 3-wait request with inputs changing mid-flight
        vt[0] = '{1'b1, 8'h05, 2'd0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h05};
        vt[1] = '{1'b0, 8'h00, 2'd0, 1'b0, 1'b1, 1'b1, 8'h3A, 8'h05};
        vt[2] = '{1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 8'h3A, 8'h05};
        vt[3] = '{1'b1, 8'h10, 2'd3, 1'b1, 1'b0, 1'b1, 8'h3A, 8'h10};
        vt[4] = '{1'b1, 8'h22, 2'd0, 1'b0, 1'b0, 1'b1, 8'h3A, 8'h10};
        vt[5] = '{1'b1, 8'h22, 2'd0, 1'b0, 1'b0, 1'b1, 8'h3A, 8'h10};
        vt[6] = '{1'b1, 8'h22, 2'd0, 1'b0, 1'b0, 1'b1, 8'h3A, 8'h10};
        vt[7] = '{1'b1, 8'h22, 2'd0, 1'b0, 1'b1, 1'b1, 8'h5C, 8'h10};
        vt[8] = '{1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 8'h5C, 8'h10};
        vt[9] = '{1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 8'h5C, 8'h10};

        e          = 0;
        model_reset();
        reset      = 1'b0;
        MemRead    = 1'b0;
        Addr       = 8'h00;
        WaitStates = 2'd0;
        repeat (2) @(posedge clock);
        #1;
        check_all_zero("reset");
        reset = 1'b1;

        for (int i = 0; i < 10; i++) begin
            cyc(vt[i].mr, vt[i].addr, vt[i].ws);
            check($sformatf("vec%0d_ArrRd", i),     {31'd0, ArrRd},     {31'd0, vt[i].rd});
            check($sformatf("vec%0d_DataValid", i), {31'd0, DataValid}, {31'd0, vt[i].dv});
            check($sformatf("vec%0d_Busy", i),      {31'd0, Busy},      {31'd0, vt[i].busy});
            check($sformatf("vec%0d_DataOut", i),   {24'd0, DataOut},   {24'd0, vt[i].dout});
            check($sformatf("vec%0d_ArrAddr", i),   {24'd0, ArrAddr},   {24'd0, vt[i].aa});
        end

        // Continuously held request: accepts every 3+WaitStates edges
        n_rd = 0;
        n_dv = 0;
        for (int i = 0; i < 12; i++) begin
            cyc(1'b1, 8'h40, 2'd1);
            check_model();
            if (ArrRd) n_rd++;
            if (DataValid) n_dv++;
            if (i == 0 || i == 4 || i == 8) check("hold_rd_slot", {31'd0, ArrRd}, 32'd1);
        end
        check("hold_rd_count", 32'(n_rd), 32'd3);
        check("hold_dv_count", 32'(n_dv), 32'd3);
        cyc(1'b0, 8'h00, 2'd0);
        cyc(1'b0, 8'h00, 2'd0);
        cyc(1'b0, 8'h00, 2'd0);
        check_model();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 3) != 0, 8'($urandom), 2'($urandom));
            check_model();
        end
        repeat (5) begin
            cyc(1'b0, 8'h00, 2'd0);
            check_model();
        end

        // Asynchronous reset in the middle of a 2-wait request
        cyc(1'b1, 8'h40, 2'd2);
        check_model();
        cyc(1'b0, 8'h00, 2'd0);
        check_model();
        #3;
        reset = 1'b0;
        #1;
        check_all_zero("midwait_reset");
        model_reset();
        n_dv = 0;
        repeat (3) begin
            @(posedge clock);
            e++;
            #1;
            if (DataValid) n_dv++;
        end
        check("reset_no_dv", 32'(n_dv), 32'd0);
        reset = 1'b1;
        cyc(1'b1, 8'h41, 2'd0);
        check_model();
        check("post_reset_rd", {31'd0, ArrRd}, 32'd1);
        repeat (3) begin
            cyc(1'b0, 8'h00, 2'd0);
            check_model();
        end
        check("post_reset_dout", {24'd0, DataOut}, 32'h94);

        // Stop word: delivered, then the block refuses further requests
        mem[8'h33] = 8'h71;
        cyc(1'b1, 8'h33, 2'd0);
        check_model();
        cyc(1'b0, 8'h00, 2'd0);
        check_model();
        check("halt_dv",     {31'd0, DataValid}, 32'd1);
        check("halt_dout",   {24'd0, DataOut},   32'h71);
        check("halt_flag",   {31'd0, Halted},    32'd1);
        n_rd = 0;
        n_dv = 0;
        for (int i = 0; i < 11; i++) begin
            cyc(1'b1, 8'($urandom), 2'($urandom));
            check_model();
            if (i > 0 && ArrRd) n_rd++;
            if (i > 0 && DataValid) n_dv++;
        end
        check("halted_rd_count", 32'(n_rd), 32'd0);
        check("halted_dv_count", 32'(n_dv), 32'd0);
        check("halted_dout",     {24'd0, DataOut}, 32'h71);
        check("halted_sticky",   {31'd0, Halted},  32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
